// File: rtl/hamming_stream_decoder.sv
// Two-stage pipelined Hamming (2^R-1, 2^R-1-R) SEC decoder with valid/ready streaming and
// saturating error counters. Define HAMMING_DEC_SECDED_EN to add the overall-parity SEC-DED mode.
module hamming_stream_decoder #(
  parameter int R     = 4,
  parameter int CNT_W = 16,
  localparam int N    = (1 << R) - 1,
  localparam int K    = N - R,
`ifdef HAMMING_DEC_SECDED_EN
  localparam int CW   = N + 1
`else
  localparam int CW   = N
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [CW-1:0]    IN_CODEWORD,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [K-1:0]     OUT_DATA,
  output logic [R-1:0]     OUT_SYNDROME,
  output logic             OUT_CORRECTED,
  output logic             OUT_UNCORRECTABLE,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] CORR_COUNT,
  output logic [CNT_W-1:0] UNCORR_COUNT
);

  function automatic logic [R-1:0] syndrome(input logic [N-1:0] cw);
    logic [R-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < R; k++)
        if (((i + 1) & (1 << k)) != 0) s[k] = s[k] ^ cw[i];
    return s;
  endfunction

  // Data bits live at the non-power-of-2 positions, packed upward from the LSB.
  function automatic logic [K-1:0] extract(input logic [N-1:0] cw);
    logic [K-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < N; i++)
      if (((i + 1) & i) != 0) begin
        d[j] = cw[i];
        j++;
      end
    return d;
  endfunction

  logic [1:0]       vld_pipe_q, vld_pipe_d;   // [0] stage 1, [1] stage 2
  logic [N-1:0]     s1_cw_q, s1_cw_d;
  logic [R-1:0]     s1_syn_q, s1_syn_d;
  logic [K-1:0]     out_data_q, out_data_d;
  logic [R-1:0]     out_syn_q, out_syn_d;
  logic             out_corr_q, out_corr_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic             s2_load, s1_adv, in_fire, out_fire;
  logic [N-1:0]     fix_cw;
  logic [R-1:0]     fix_idx;
  logic             fix_corr, fix_unc;
`ifdef HAMMING_DEC_SECDED_EN
  logic             s1_par_q, s1_par_d;
  logic             out_unc_q, out_unc_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
`endif

  assign s2_load  = !vld_pipe_q[1] | OUT_READY;
  assign s1_adv   = vld_pipe_q[0] & s2_load;
  assign IN_READY = !vld_pipe_q[0] | s1_adv;
  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = vld_pipe_q[1] & OUT_READY;

  always_comb begin
    fix_cw   = s1_cw_q;
    fix_idx  = s1_syn_q - R'(1);
    fix_corr = 1'b0;
    fix_unc  = 1'b0;
`ifdef HAMMING_DEC_SECDED_EN
    // Parity mismatch means an odd error count; zero syndrome then blames the parity bit itself.
    if (s1_par_q) begin
      fix_corr = 1'b1;
      if (s1_syn_q != '0) fix_cw[fix_idx] = ~s1_cw_q[fix_idx];
    end else if (s1_syn_q != '0) begin
      fix_unc = 1'b1;
    end
`else
    if (s1_syn_q != '0) begin
      fix_corr        = 1'b1;
      fix_cw[fix_idx] = ~s1_cw_q[fix_idx];
    end
`endif
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    out_data_d = out_data_q;
    out_syn_d  = out_syn_q;
    out_corr_d = out_corr_q;
`ifdef HAMMING_DEC_SECDED_EN
    s1_par_d   = s1_par_q;
    out_unc_d  = out_unc_q;
`endif
    if (in_fire) begin
      vld_pipe_d[0] = 1'b1;
      s1_cw_d       = IN_CODEWORD[N-1:0];
      s1_syn_d      = syndrome(IN_CODEWORD[N-1:0]);
`ifdef HAMMING_DEC_SECDED_EN
      s1_par_d      = ^IN_CODEWORD;
`endif
    end else if (s1_adv) begin
      vld_pipe_d[0] = 1'b0;
    end
    // Payload only changes when a real word moves in, so a stalled output stays put.
    if (s2_load) begin
      vld_pipe_d[1] = vld_pipe_q[0];
      if (vld_pipe_q[0]) begin
        out_data_d = extract(fix_cw);
        out_syn_d  = s1_syn_q;
        out_corr_d = fix_corr;
`ifdef HAMMING_DEC_SECDED_EN
        out_unc_d  = fix_unc;
`endif
      end
    end
  end

  always_comb begin
    corr_cnt_d = corr_cnt_q;
    if (CNT_CLR) corr_cnt_d = '0;
    else if (out_fire && out_corr_q && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
`ifdef HAMMING_DEC_SECDED_EN
    uncorr_cnt_d = uncorr_cnt_q;
    if (CNT_CLR) uncorr_cnt_d = '0;
    else if (out_fire && out_unc_q && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe_q   <= '0;
      s1_cw_q      <= '0;
      s1_syn_q     <= '0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      corr_cnt_q   <= '0;
`ifdef HAMMING_DEC_SECDED_EN
      s1_par_q     <= 1'b0;
      out_unc_q    <= 1'b0;
      uncorr_cnt_q <= '0;
`endif
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      s1_cw_q      <= s1_cw_d;
      s1_syn_q     <= s1_syn_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_corr_q   <= out_corr_d;
      corr_cnt_q   <= corr_cnt_d;
`ifdef HAMMING_DEC_SECDED_EN
      s1_par_q     <= s1_par_d;
      out_unc_q    <= out_unc_d;
      uncorr_cnt_q <= uncorr_cnt_d;
`endif
    end
  end

  assign OUT_VALID     = vld_pipe_q[1];
  assign OUT_DATA      = out_data_q;
  assign OUT_SYNDROME  = out_syn_q;
  assign OUT_CORRECTED = out_corr_q;
  assign CORR_COUNT    = corr_cnt_q;
`ifdef HAMMING_DEC_SECDED_EN
  assign OUT_UNCORRECTABLE = out_unc_q;
  assign UNCORR_COUNT      = uncorr_cnt_q;
`else
  assign OUT_UNCORRECTABLE = fix_unc & 1'b0;
  assign UNCORR_COUNT      = '0;
`endif

endmodule
